// File: rtl/mobo_router_pkg.sv
// mobo_router_pkg: control/status codes, router states, error causes and a select-width helper
package mobo_router_pkg;
  localparam logic [31:0] CTRL_READ = 32'd1;
  localparam logic [31:0] CTRL_WRITE = 32'd2;
  localparam logic [31:0] STAT_IDLE = 32'd0;
  localparam logic [31:0] STAT_DONE = 32'd1;
  localparam logic [31:0] STAT_ERR = 32'd2;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_DONE} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_MISS, ERR_TMO, ERR_CTRL} err_t;
  function automatic int sel_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mobo_decode.sv
// mobo_decode: splits addr into device sel, window hit and local laddr (combinational)
module mobo_decode
  import mobo_router_pkg::*;
#(
  parameter int W = 32,
  parameter int N_DEV = 2,
  parameter int WIN_BITS = 16,
  parameter int SW = sel_bits(N_DEV)
) (
  input  logic [W-1:0]  addr,
  output logic [SW-1:0] sel,
  output logic          hit,
  output logic [W-1:0]  laddr
);
  logic [W-1:0] win;
  logic [W-1:0] mask;
  assign win = addr >> WIN_BITS;
  assign mask = ~({W{1'b1}} << WIN_BITS);
  assign hit = win < W'(N_DEV);
  assign sel = win[SW-1:0];
  assign laddr = addr & mask;
endmodule

// File: rtl/mobo_router.sv
// mobo_router: routes one CPU transaction (cpu_ctrl/stat/addr/wdata/rdata) to device channel dev_ctrl/stat/rdata[i], with timeout and last_err cause
module mobo_router
  import mobo_router_pkg::*;
#(
  parameter int W = 32,
  parameter int N_DEV = 2,
  parameter int WIN_BITS = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       cpu_ctrl,
  output logic [W-1:0]       cpu_stat,
  input  logic [W-1:0]       cpu_addr,
  input  logic [W-1:0]       cpu_wdata,
  output logic [W-1:0]       cpu_rdata,
  output logic [N_DEV*W-1:0] dev_ctrl,
  input  logic [N_DEV*W-1:0] dev_stat,
  output logic [W-1:0]       dev_addr,
  output logic [W-1:0]       dev_wdata,
  input  logic [N_DEV*W-1:0] dev_rdata,
  output logic [1:0]         last_err
);
  localparam int SW = sel_bits(N_DEV);
  localparam logic [W-1:0] BOTH = W'(CTRL_READ | CTRL_WRITE);
  state_t state;
  logic [SW-1:0] sel, dsel;
  logic hit, rd, tmo;
  logic [W-1:0] laddr, stat, rdata;
  logic [31:0] cnt;
  mobo_decode #(.W(W), .N_DEV(N_DEV), .WIN_BITS(WIN_BITS), .SW(SW)) u_dec (
    .addr(cpu_addr), .sel(dsel), .hit(hit), .laddr(laddr)
  );
  assign stat = dev_stat[sel*W +: W];
  assign rdata = dev_rdata[sel*W +: W];
  assign tmo = TIMEOUT != 0 && cnt == 32'(TIMEOUT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      sel <= '0;
      rd <= 1'b0;
      cnt <= '0;
      cpu_stat <= W'(STAT_IDLE);
      cpu_rdata <= '0;
      dev_ctrl <= '0;
      dev_addr <= '0;
      dev_wdata <= '0;
      last_err <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: if (cpu_ctrl != '0) begin
          sel <= dsel;
          rd <= (cpu_ctrl & W'(CTRL_READ)) != '0;
          if ((cpu_ctrl & BOTH) == BOTH) begin
            cpu_stat <= W'(STAT_ERR);
            last_err <= ERR_CTRL;
            state <= S_DONE;
          end else if (!hit) begin
            cpu_stat <= W'(STAT_ERR);
            last_err <= ERR_MISS;
            state <= S_DONE;
          end else begin
            dev_ctrl[dsel*W +: W] <= cpu_ctrl;
            dev_addr <= laddr;
            dev_wdata <= cpu_wdata;
            cnt <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: if (stat == W'(STAT_DONE)) begin
          if (rd) cpu_rdata <= rdata;
          dev_ctrl <= '0;
          cnt <= '0;
          state <= S_REL;
        end else if (tmo) begin
          dev_ctrl <= '0;
          cpu_stat <= W'(STAT_ERR);
          last_err <= ERR_TMO;
          state <= S_DONE;
        end else cnt <= &cnt ? cnt : cnt + 32'd1;
        S_REL: if (stat == W'(STAT_IDLE)) begin
          cpu_stat <= W'(STAT_DONE);
          last_err <= ERR_NONE;
          state <= S_DONE;
        end else if (tmo) begin
          cpu_stat <= W'(STAT_ERR);
          last_err <= ERR_TMO;
          state <= S_DONE;
        end else cnt <= &cnt ? cnt : cnt + 32'd1;
        S_DONE: if (cpu_ctrl == '0) begin
          cpu_stat <= W'(STAT_IDLE);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mobo_router.sv
// tb_mobo_router: table-driven check of mobo_router with wait-state device models on two channels
module tb_mobo_router;
  localparam int W = 32;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] cpu_ctrl, cpu_stat, cpu_addr, cpu_wdata, cpu_rdata, dev_addr, dev_wdata;
  logic [N*W-1:0] dev_ctrl, dev_stat, dev_rdata;
  logic [1:0] last_err;
  logic [31:0] dcnt [N];
  int unsigned wait_c [N];
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [31:0] ctrl, addr, wdata;
    int unsigned w0, w1;
    int edges;
    logic [31:0] stat;
    logic [1:0] err;
    logic [31:0] rdata;
    logic [63:0] dc1;
    logic [31:0] daddr, dwdata, o0, o1;
  } vec_t;
  vec_t tbl [8];
  mobo_router #(.W(W), .N_DEV(N), .WIN_BITS(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cpu_ctrl(cpu_ctrl), .cpu_stat(cpu_stat), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dev_ctrl(dev_ctrl), .dev_stat(dev_stat),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .last_err(last_err)
  );
  always #5 clk = ~clk;
  assign dev_rdata = {32'hCAFEF00D, 32'h12345678};
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      dcnt[i] <= (rst || dev_ctrl[i*W +: W] == '0) ? 32'd0 : dcnt[i] + 32'd1;
  end
  always_comb begin
    dev_stat = '0;
    for (int i = 0; i < N; i++)
      dev_stat[i*W +: W] = (dev_ctrl[i*W +: W] != '0 && dcnt[i] >= wait_c[i]) ? 32'd1 : 32'd0;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input int idx);
    int edges;
    logic [31:0] o0, o1;
    wait_c[0] = v.w0;
    wait_c[1] = v.w1;
    @(posedge clk); #1;
    cpu_ctrl = v.ctrl;
    cpu_addr = v.addr;
    cpu_wdata = v.wdata;
    edges = 0;
    o0 = '0;
    o1 = '0;
    do begin
      @(posedge clk); #1;
      edges++;
      o0 |= dev_ctrl[31:0];
      o1 |= dev_ctrl[63:32];
      if (edges == 1) begin
        chk($sformatf("v%0d dev_ctrl@1", idx), dev_ctrl, v.dc1);
        if (v.dc1 != '0) begin
          chk($sformatf("v%0d dev_addr", idx), {32'd0, dev_addr}, {32'd0, v.daddr});
          chk($sformatf("v%0d dev_wdata", idx), {32'd0, dev_wdata}, {32'd0, v.dwdata});
        end
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
      end
    end while (cpu_stat == '0 && edges < 40);
    chk($sformatf("v%0d edges", idx), 64'(edges), 64'(v.edges));
    chk($sformatf("v%0d cpu_stat", idx), {32'd0, cpu_stat}, {32'd0, v.stat});
    chk($sformatf("v%0d last_err", idx), {62'd0, last_err}, {62'd0, v.err});
    chk($sformatf("v%0d cpu_rdata", idx), {32'd0, cpu_rdata}, {32'd0, v.rdata});
    chk($sformatf("v%0d ch0 seen", idx), {32'd0, o0}, {32'd0, v.o0});
    chk($sformatf("v%0d ch1 seen", idx), {32'd0, o1}, {32'd0, v.o1});
    chk($sformatf("v%0d dev_ctrl end", idx), dev_ctrl, 64'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d stat hold", idx), {32'd0, cpu_stat}, {32'd0, v.stat});
    cpu_ctrl = '0;
    @(posedge clk); #1;
    chk($sformatf("v%0d stat idle", idx), {32'd0, cpu_stat}, 64'd0);
  endtask
  initial begin
    tbl[0] = '{32'd2, 32'h0001_0004, 32'hDEADBEEF, 0, 0, 3, 32'd1, 2'd0, 32'h0, 64'h2_0000_0000, 32'h4, 32'hDEADBEEF, 32'h0, 32'h2};
    tbl[1] = '{32'd1, 32'h0000_0010, 32'h11111111, 3, 0, 6, 32'd1, 2'd0, 32'h12345678, 64'h1, 32'h10, 32'h11111111, 32'h1, 32'h0};
    tbl[2] = '{32'd1, 32'h0002_0000, 32'h0, 0, 0, 1, 32'd2, 2'd1, 32'h12345678, 64'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{32'd3, 32'h0000_0000, 32'h0, 0, 0, 1, 32'd2, 2'd3, 32'h12345678, 64'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{32'd1, 32'h0000_0020, 32'h22222222, 255, 0, 10, 32'd2, 2'd2, 32'h12345678, 64'h1, 32'h20, 32'h22222222, 32'h1, 32'h0};
    tbl[5] = '{32'd1, 32'h0001_FFFF, 32'h33333333, 0, 1, 4, 32'd1, 2'd0, 32'hCAFEF00D, 64'h1_0000_0000, 32'hFFFF, 32'h33333333, 32'h0, 32'h1};
    tbl[6] = '{32'd2, 32'h0000_0000, 32'h55AA55AA, 7, 0, 10, 32'd1, 2'd0, 32'hCAFEF00D, 64'h2, 32'h0, 32'h55AA55AA, 32'h2, 32'h0};
    tbl[7] = '{32'd1, 32'h0000_0010, 32'h0, 0, 0, 3, 32'd1, 2'd0, 32'h12345678, 64'h1, 32'h10, 32'h0, 32'h1, 32'h0};
    wait_c[0] = 0;
    wait_c[1] = 0;
    cpu_ctrl = '0;
    cpu_addr = '0;
    cpu_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset cpu_stat", {32'd0, cpu_stat}, 64'd0);
    chk("reset dev_ctrl", dev_ctrl, 64'd0);
    chk("reset cpu_rdata", {32'd0, cpu_rdata}, 64'd0);
    chk("reset last_err", {62'd0, last_err}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run(tbl[i], i);
    wait_c[0] = 255;
    @(posedge clk); #1;
    cpu_ctrl = 32'd1;
    cpu_addr = 32'h0000_0010;
    cpu_wdata = 32'h77777777;
    @(posedge clk); #1;
    chk("pre-reset dev_ctrl", dev_ctrl, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst dev_ctrl", dev_ctrl, 64'd0);
    chk("async rst cpu_stat", {32'd0, cpu_stat}, 64'd0);
    chk("async rst cpu_rdata", {32'd0, cpu_rdata}, 64'd0);
    chk("async rst dev_addr", {32'd0, dev_addr}, 64'd0);
    chk("async rst dev_wdata", {32'd0, dev_wdata}, 64'd0);
    cpu_ctrl = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    run(tbl[7], 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
